// File: rtl/byte_splitter_if.sv
// Bus interface for byte_splitter: the word/control inputs and the
// registered byte-lane, flag and valid outputs.
// Optional feature: define SPLITTER_PARITY_EN to add the per-lane parity bus P.
interface byte_splitter_if;
    logic [31:0] A;      // word to split
    logic        en;     // load enable
    logic        swap;   // 0: O1 gets MSB, 1: byte order reversed
    logic [7:0]  O1;     // byte lane 1
    logic [7:0]  O2;     // byte lane 2
    logic [7:0]  O3;     // byte lane 3
    logic [7:0]  O4;     // byte lane 4
    logic [3:0]  Z;      // Z[i] set when lane O(i+1) is zero
    logic        valid;  // at least one word captured since reset
`ifdef SPLITTER_PARITY_EN
    logic [3:0]  P;      // P[i] = XOR of lane O(i+1) bits
`endif

    // Driver side: supplies the word and control, observes the lanes.
    modport master (
        output A, en, swap,
        input  O1, O2, O3, O4, Z, valid
`ifdef SPLITTER_PARITY_EN
        , input P
`endif
    );

    // Splitter side: consumes the word and control, drives the lanes.
    modport slave (
        input  A, en, swap,
        output O1, O2, O3, O4, Z, valid
`ifdef SPLITTER_PARITY_EN
        , output P
`endif
    );
endinterface

// File: rtl/byte_splitter.sv
// Registered word-to-byte splitter. A 32-bit word is captured on a clock
// edge with en high and its four bytes are presented on O1..O4 in either
// MSB-first (swap = 0) or LSB-first (swap = 1) order, together with
// per-lane zero flags and a sticky valid flag.
// Optional feature: define SPLITTER_PARITY_EN to add registered per-lane
// parity P[3:0]; with the macro undefined the port and its logic are absent.
module byte_splitter (
    input  logic            clk,
    input  logic            reset,
    byte_splitter_if.slave  bus
);

    // Lane index 0 corresponds to O1, index 3 to O4.
    logic [3:0][7:0] lane_d;
    logic [3:0][7:0] lane_q;
    logic [3:0]      z_d;
    logic [3:0]      z_q;
    logic            valid_q;
`ifdef SPLITTER_PARITY_EN
    logic [3:0]      p_d;
    logic [3:0]      p_q;
`endif

    // Select the byte order of the incoming word and derive flags from the
    // lanes about to be loaded, so flags always match the lanes they describe.
    always_comb begin
        // NOTE: every signal gets a value before any conditional logic, so no latch can be inferred.
        lane_d = '0;
        z_d    = '0;
`ifdef SPLITTER_PARITY_EN
        p_d    = '0;
`endif
        for (int i = 0; i < 4; i++) begin
            lane_d[i] = bus.swap ? bus.A[8*i +: 8] : bus.A[8*(3-i) +: 8];
            z_d[i]    = (lane_d[i] == 8'h00);
`ifdef SPLITTER_PARITY_EN
            p_d[i]    = ^lane_d[i];
`endif
        end
    end

    // Capture register: reset to an all-zero lane image, load on en, else hold.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled only at the clock edge and takes priority over en, so a word presented with reset is discarded.
        if (reset) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
            lane_q  <= '0;
            z_q     <= 4'b1111;
            valid_q <= 1'b0;
`ifdef SPLITTER_PARITY_EN
            p_q     <= 4'b0000;
`endif
        end else if (bus.en) begin
            lane_q  <= lane_d;
            z_q     <= z_d;
            valid_q <= 1'b1;
`ifdef SPLITTER_PARITY_EN
            p_q     <= p_d;
`endif
        end
    end

    // Outputs come straight from registers; no input reaches them combinationally.
    assign bus.O1    = lane_q[0];
    assign bus.O2    = lane_q[1];
    assign bus.O3    = lane_q[2];
    assign bus.O4    = lane_q[3];
    assign bus.Z     = z_q;
    assign bus.valid = valid_q;
`ifdef SPLITTER_PARITY_EN
    assign bus.P     = p_q;
`endif

endmodule

// File: tb/tb_byte_splitter.sv
// Self-checking bench for byte_splitter. A behavioural model holds the
// expected byte image of the last captured word; each scenario task drives
// stimulus one cycle at a time and compares every output after the edge.
// Optional feature: SPLITTER_PARITY_EN (also enables the parity checks here).
module tb_byte_splitter;

`ifdef SPLITTER_PARITY_EN
    localparam int OBS_W = 41;
`else
    localparam int OBS_W = 37;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    byte_splitter_if bus ();

    byte_splitter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: the four expected lane bytes and the sticky valid.
    logic [7:0] m_lane [4];
    logic       m_valid;

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) m_lane[k] = 8'h00;
        m_valid = 1'b0;
    endfunction

    // Lane k (O(k+1)) holds byte (3-k) of the word in normal order and
    // byte k in swapped order; bytes are extracted by shifting.
    function automatic void model_capture(input logic [31:0] a, input logic s);
        for (int k = 0; k < 4; k++) begin
            int unsigned sh;
            sh = s ? 8 * k : 8 * (3 - k);
            m_lane[k] = 8'((a >> sh) & 32'hFF);
        end
        m_valid = 1'b1;
    endfunction

    // Expected output vector {O1,O2,O3,O4,Z,valid[,P]} from the model.
    function automatic logic [OBS_W-1:0] expected();
        logic [3:0] z;
        logic [3:0] p;
        for (int k = 0; k < 4; k++) begin
            int ones;
            ones = 0;
            for (int b = 0; b < 8; b++) ones += int'(m_lane[k][b]);
            z[k] = (m_lane[k] == 8'h00);
            p[k] = (ones % 2) == 1;
        end
`ifdef SPLITTER_PARITY_EN
        return {m_lane[0], m_lane[1], m_lane[2], m_lane[3], z, m_valid, p};
`else
        return {m_lane[0], m_lane[1], m_lane[2], m_lane[3], z, m_valid};
`endif
    endfunction

    function automatic logic [OBS_W-1:0] observed();
`ifdef SPLITTER_PARITY_EN
        return {bus.O1, bus.O2, bus.O3, bus.O4, bus.Z, bus.valid, bus.P};
`else
        return {bus.O1, bus.O2, bus.O3, bus.O4, bus.Z, bus.valid};
`endif
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, and return
    // 1 ns after the edge so outputs are sampled away from it.
    task automatic cycle(input logic r, input logic e, input logic s, input logic [31:0] a);
        reset    = r;
        bus.en   = e;
        bus.swap = s;
        bus.A    = a;
        @(posedge clk);
        if (r)      model_reset();
        else if (e) model_capture(a, s);
        #1;
    endtask

    task automatic test_reset();
        logic [OBS_W-1:0] exp_v;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
`ifdef SPLITTER_PARITY_EN
        exp_v = {8'h00, 8'h00, 8'h00, 8'h00, 4'b1111, 1'b0, 4'b0000};
`else
        exp_v = {8'h00, 8'h00, 8'h00, 8'h00, 4'b1111, 1'b0};
`endif
        n_checks++;
        if (observed() !== exp_v) begin
            n_fails++;
            $display("FAIL reset_values: got %h expected %h", observed(), exp_v);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_capture();
        logic [31:0] words [4] = '{32'h0000ABCD, 32'h000004A5, 32'h00004514, 32'h000096EE};
        logic [15:0] lo    [4] = '{16'hABCD, 16'h04A5, 16'h4514, 16'h96EE};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0, words[i]);
            n_checks++;
            if ({bus.O1, bus.O2, bus.O3, bus.O4, bus.Z, bus.valid} !== {16'h0000, lo[i], 4'b0011, 1'b1}) begin
                n_fails++;
                $display("FAIL capture_%0d: got O=%h%h%h%h Z=%b v=%b expected O=0000%h Z=0011 v=1",
                         i, bus.O1, bus.O2, bus.O3, bus.O4, bus.Z, bus.valid, lo[i]);
            end
            n_checks++;
            if (observed() !== expected()) begin
                n_fails++;
                $display("FAIL capture_model_%0d: got %h expected %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_swap();
        cycle(1'b0, 1'b1, 1'b1, 32'h12345678);
        n_checks++;
        if ({bus.O1, bus.O2, bus.O3, bus.O4, bus.Z} !== {32'h78563412, 4'b0000}) begin
            n_fails++;
            $display("FAIL swap: got O=%h%h%h%h Z=%b expected O=78563412 Z=0000",
                     bus.O1, bus.O2, bus.O3, bus.O4, bus.Z);
        end
        // Swapped word with zero bytes at both ends exercises flags in reverse order.
        cycle(1'b0, 1'b1, 1'b1, 32'h00AB0000);
        n_checks++;
        if (observed() !== expected()) begin
            n_fails++;
            $display("FAIL swap_zero_lanes: got %h expected %h", observed(), expected());
        end
    endtask

    task automatic test_hold();
        logic [OBS_W-1:0] exp_v;
        cycle(1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            n_checks++;
            if ({bus.O1, bus.O2, bus.O3, bus.O4, bus.valid} !== {32'hDEADBEEF, 1'b1}) begin
                n_fails++;
                $display("FAIL hold_%0d: got O=%h%h%h%h v=%b expected O=deadbeef v=1",
                         i, bus.O1, bus.O2, bus.O3, bus.O4, bus.valid);
            end
        end
        // Reset and en together: reset wins, the all-ones word is discarded.
        cycle(1'b1, 1'b1, 1'b0, 32'hFFFFFFFF);
`ifdef SPLITTER_PARITY_EN
        exp_v = {32'h0, 4'b1111, 1'b0, 4'b0000};
`else
        exp_v = {32'h0, 4'b1111, 1'b0};
`endif
        n_checks++;
        if (observed() !== exp_v) begin
            n_fails++;
            $display("FAIL reset_beats_en: got %h expected %h", observed(), exp_v);
        end
        // First en-high edge after reset captures normally.
        cycle(1'b0, 1'b1, 1'b0, 32'h00FF0180);
        n_checks++;
        if (observed() !== expected()) begin
            n_fails++;
            $display("FAIL capture_after_reset: got %h expected %h", observed(), expected());
        end
    endtask

    task automatic test_parity();
`ifdef SPLITTER_PARITY_EN
        cycle(1'b0, 1'b1, 1'b0, 32'h01030700);
        n_checks++;
        if (bus.P !== 4'b0101) begin
            n_fails++;
            $display("FAIL parity: got P=%b expected P=0101", bus.P);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'hFFFFFFFE);
        n_checks++;
        if (bus.P !== 4'b0101) begin
            n_fails++;
            $display("FAIL parity_hold: got P=%b expected P=0101", bus.P);
        end
`endif
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'(i % 2), $urandom);
            n_checks++;
            if (observed() !== expected()) begin
                n_fails++;
                $display("FAIL back_to_back_%0d: got %h expected %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom;
            // Zero random bytes often so the zero flags see every pattern.
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 2) == 0) a[8*b +: 8] = 8'h00;
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), a);
            n_checks++;
            if (observed() !== expected()) begin
                n_fails++;
                $display("FAIL random_%0d: got %h expected %h", i, observed(), expected());
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        bus.en   = 1'b0;
        bus.swap = 1'b0;
        bus.A    = 32'h0;
        model_reset();
        test_reset();
        test_capture();
        test_swap();
        test_hold();
        test_parity();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
